cpu_regfile_mp: RTL and testbench

Parametrised successor of the CPU general-purpose register file. Provides NUM_RD combinational read ports and one write port, with write-to-read bypass. It also contains an interrupt link-capture state machine. That machine stores PC+PC_INC into the link register exactly once per interrupt entry, and defers the capture by one cycle when it collides with a software write to the same register. Sits between decode (read addresses) and writeback (write port), and takes PC and IRQ from the fetch/exception logic.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/regfile_link_fsm.sv | 90 +++++++++
 rtl/cpu_regfile_mp.sv | 82 ++++++++
 tb/tb_cpu_regfile_mp.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU register file: link-capture FSM encoding,
// default link register / PC increment and the kernel-flag bit position.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        WAIT_K  = 2'd2,
        IN_K    = 2'd3
    } link_state_t;

    localparam int LINK_REG_DEFAULT = 31;
    localparam int PC_INC_DEFAULT   = 4;

    // The kernel-mode flag lives in the MSB of the PC.
    function automatic int kernel_bit(input int data_w);
        return data_w - 1;
    endfunction

endpackage

// File: rtl/regfile_link_fsm.sv
// Interrupt link-capture FSM: stores PC+PC_INC into the link register once per
// kernel round trip, deferring by one cycle when software writes the same register.
module regfile_link_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = LINK_REG_DEFAULT,
    parameter int PC_INC   = PC_INC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pc,
    input  logic              irq,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              link_we,
    output logic [DATA_W-1:0] link_data,
    output logic              irq_ack,
    output logic              link_busy
);

    localparam int                KB        = kernel_bit(DATA_W);
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [DATA_W-2:0] INC       = (DATA_W-1)'(PC_INC);

    link_state_t       state_reg;
    logic [DATA_W-1:0] shadow_reg;
    logic              irq_ack_reg;
    logic              link_busy_reg;

    logic              kernel;
    logic [DATA_W-1:0] link_value;
    logic              trigger;
    logic              collide;

    // The increment wraps within the low bits; the kernel flag passes through untouched.
    assign kernel     = pc[KB];
    assign link_value = {kernel, pc[KB-1:0] + INC};
    assign trigger    = irq && !kernel && (state_reg == IDLE);
    assign collide    = wr_en && (wr_addr == LINK_ADDR);

    assign link_we    = (trigger && !collide) || (state_reg == PENDING);
    assign link_data  = (state_reg == PENDING) ? shadow_reg : link_value;
    assign irq_ack    = irq_ack_reg;
    assign link_busy  = link_busy_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            shadow_reg    <= '0;
            irq_ack_reg   <= 1'b0;
            link_busy_reg <= 1'b0;
        end else begin
            irq_ack_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (trigger) begin
                        link_busy_reg <= 1'b1;
                        if (collide) begin
                            shadow_reg <= link_value;
                            state_reg  <= PENDING;
                        end else begin
                            irq_ack_reg <= 1'b1;
                            state_reg   <= WAIT_K;
                        end
                    end
                end
                PENDING: begin
                    irq_ack_reg <= 1'b1;
                    state_reg   <= WAIT_K;
                end
                WAIT_K: begin
                    if (kernel) state_reg <= IN_K;
                end
                IN_K: begin
                    if (!kernel) begin
                        state_reg     <= IDLE;
                        link_busy_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    link_busy_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_regfile_mp.sv
// Multi-port CPU register file: NUM_RD combinational read ports with write-first
// bypass, one write port, register 0 hardwired to zero, interrupt link capture.
module cpu_regfile_mp
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int LINK_REG = LINK_REG_DEFAULT,
    parameter int PC_INC   = PC_INC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W-1:0]        pc,
    input  logic                     irq,
    output logic                     irq_ack,
    output logic                     link_busy
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs [DEPTH];
    logic              link_we;
    logic [DATA_W-1:0] link_data;

    regfile_link_fsm #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LINK_REG(LINK_REG),
        .PC_INC  (PC_INC)
    ) u_link_fsm (
        .clk      (clk),
        .reset    (reset),
        .pc       (pc),
        .irq      (irq),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .link_we  (link_we),
        .link_data(link_data),
        .irq_ack  (irq_ack),
        .link_busy(link_busy)
    );

    // The link write is issued last so it overrides a same-cycle software write
    // to the link register while the deferred capture commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
            if (link_we) regs[LINK_ADDR] <= link_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] val;

            assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                val = regs[addr];
                if (addr == '0)
                    val = '0;
                else if (link_we && (addr == LINK_ADDR))
                    val = link_data;
                else if (wr_en && (wr_addr == addr))
                    val = wr_data;
            end

            assign rd_data[gi*DATA_W +: DATA_W] = val;
        end
    endgenerate

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Scoreboard bench for cpu_regfile_mp: expected values are queued when stimulus
// is driven and popped when the corresponding output is sampled.
module tb_cpu_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [DW-1:0]    pc;
    logic             irq;
    logic             irq_ack;
    logic             link_busy;

    logic [DW-1:0] rd0, rd1;
    assign rd0 = rd_data[DW-1:0];
    assign rd1 = rd_data[2*DW-1:DW];

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   exp_q [$];
    logic [31:0]   got, exp;

    cpu_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .pc       (pc),
        .irq      (irq),
        .irq_ack  (irq_ack),
        .link_busy(link_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic return_to_idle;
        irq = 1'b0;
        pc  = 32'h8000_0100;
        tick();
        tick();
        pc  = 32'h0040_0000;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pc = 32'h0040_0000; irq = 1'b0; set_rd(0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0055;
        tick();
        wr_en = 1'b0; set_rd(3, 31);
        exp_q.push_back(32'h0000_0055);
        #1;
        exp = exp_q.pop_front(); got = rd0; checks++;
        if (got !== exp) begin errors++; $display("FAIL pre_reset_write: got %h, expected %h", got, exp); end
        else $display("pass pre_reset_write %h", got);
        #2 reset = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); got = rd0; checks++;
        if (got !== exp) begin errors++; $display("FAIL async_clear_r3: got %h, expected %h", got, exp); end
        else $display("pass async_clear_r3 %h", got);
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL async_clear_r31: got %h, expected %h", got, exp); end
        else $display("pass async_clear_r31 %h", got);
        exp = exp_q.pop_front(); got = 32'(link_busy); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_link_busy: got %h, expected %h", got, exp); end
        else $display("pass reset_link_busy %h", got);
        exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_irq_ack: got %h, expected %h", got, exp); end
        else $display("pass reset_irq_ack %h", got);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        @(negedge clk) reset = 1'b0;
        tick();
        wr_en = 1'b0; set_rd(5, 0);
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        exp = exp_q.pop_front(); got = rd0; checks++;
        if (got !== exp) begin errors++; $display("FAIL write_after_reset: got %h, expected %h", got, exp); end
        else $display("pass write_after_reset %h", got);
    endtask

    task automatic test_bypass;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678; set_rd(0, 7);
        exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_same_cycle: got %h, expected %h", got, exp); end
        else $display("pass bypass_same_cycle %h", got);
        exp = exp_q.pop_front(); got = rd0; checks++;
        if (got !== exp) begin errors++; $display("FAIL bypass_r0_port0: got %h, expected %h", got, exp); end
        else $display("pass bypass_r0_port0 %h", got);
        tick();
        wr_en = 1'b0;
        exp_q.push_back(32'h1234_5678);
        #1;
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL stored_r7: got %h, expected %h", got, exp); end
        else $display("pass stored_r7 %h", got);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; set_rd(0, 0);
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); got = rd0; checks++;
        if (got !== exp) begin errors++; $display("FAIL r0_bypass_blocked: got %h, expected %h", got, exp); end
        else $display("pass r0_bypass_blocked %h", got);
        tick();
        wr_en = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); got = rd0; checks++;
        if (got !== exp) begin errors++; $display("FAIL r0_write_discarded: got %h, expected %h", got, exp); end
        else $display("pass r0_write_discarded %h", got);
    endtask

    task automatic test_capture;
        set_rd(0, 31); pc = 32'h0040_0010; irq = 1'b1;
        exp_q.push_back(32'h0040_0014);
        #1;
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL capture_bypass: got %h, expected %h", got, exp); end
        else $display("pass capture_bypass %h", got);
        exp_q.push_back(32'h1); exp_q.push_back(32'h1); exp_q.push_back(32'h0040_0014);
        tick();
        exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
        if (got !== exp) begin errors++; $display("FAIL capture_irq_ack: got %h, expected %h", got, exp); end
        else $display("pass capture_irq_ack %h", got);
        exp = exp_q.pop_front(); got = 32'(link_busy); checks++;
        if (got !== exp) begin errors++; $display("FAIL capture_link_busy: got %h, expected %h", got, exp); end
        else $display("pass capture_link_busy %h", got);
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL capture_r31: got %h, expected %h", got, exp); end
        else $display("pass capture_r31 %h", got);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(32'h0);
            tick();
            exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
            if (got !== exp) begin errors++; $display("FAIL held_irq_no_ack[%0d]: got %h, expected %h", i, got, exp); end
            else $display("pass held_irq_no_ack[%0d] %h", i, got);
        end
    endtask

    task automatic test_round_trip;
        irq = 1'b0; pc = 32'h8000_0180;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'h1);
            tick();
            exp = exp_q.pop_front(); got = 32'(link_busy); checks++;
            if (got !== exp) begin errors++; $display("FAIL kernel_busy[%0d]: got %h, expected %h", i, got, exp); end
            else $display("pass kernel_busy[%0d] %h", i, got);
        end
        pc = 32'h0040_0024;
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front(); got = 32'(link_busy); checks++;
        if (got !== exp) begin errors++; $display("FAIL return_busy_falls: got %h, expected %h", got, exp); end
        else $display("pass return_busy_falls %h", got);
        irq = 1'b1;
        exp_q.push_back(32'h1); exp_q.push_back(32'h0040_0028);
        tick();
        exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
        if (got !== exp) begin errors++; $display("FAIL recapture_ack: got %h, expected %h", got, exp); end
        else $display("pass recapture_ack %h", got);
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL recapture_r31: got %h, expected %h", got, exp); end
        else $display("pass recapture_r31 %h", got);
        return_to_idle();
    endtask

    task automatic test_collision;
        pc = 32'h0040_0020; irq = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hAAAA_0000; set_rd(0, 31);
        exp_q.push_back(32'hAAAA_0000);
        #1;
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL collide_sw_bypass: got %h, expected %h", got, exp); end
        else $display("pass collide_sw_bypass %h", got);
        exp_q.push_back(32'h0); exp_q.push_back(32'h1);
        tick();
        exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
        if (got !== exp) begin errors++; $display("FAIL collide_edge1_ack: got %h, expected %h", got, exp); end
        else $display("pass collide_edge1_ack %h", got);
        exp = exp_q.pop_front(); got = 32'(link_busy); checks++;
        if (got !== exp) begin errors++; $display("FAIL collide_edge1_busy: got %h, expected %h", got, exp); end
        else $display("pass collide_edge1_busy %h", got);
        wr_data = 32'h5555_AAAA;
        exp_q.push_back(32'h0040_0024);
        #1;
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL pending_link_priority: got %h, expected %h", got, exp); end
        else $display("pass pending_link_priority %h", got);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0040_0024);
        tick();
        wr_en = 1'b0;
        exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
        if (got !== exp) begin errors++; $display("FAIL collide_edge2_ack: got %h, expected %h", got, exp); end
        else $display("pass collide_edge2_ack %h", got);
        #1;
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL pending_write_discarded: got %h, expected %h", got, exp); end
        else $display("pass pending_write_discarded %h", got);
        exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
        if (got !== exp) begin errors++; $display("FAIL collide_ack_single: got %h, expected %h", got, exp); end
        else $display("pass collide_ack_single %h", got);
        return_to_idle();
    endtask

    task automatic test_wrap_kernel;
        pc = 32'h7FFF_FFFC; irq = 1'b1; set_rd(0, 31);
        exp_q.push_back(32'h1); exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_ack: got %h, expected %h", got, exp); end
        else $display("pass wrap_ack %h", got);
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_r31: got %h, expected %h", got, exp); end
        else $display("pass wrap_r31 %h", got);
        return_to_idle();
        pc = 32'h8000_0000; irq = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        tick();
        tick();
        exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
        if (got !== exp) begin errors++; $display("FAIL kernel_no_ack: got %h, expected %h", got, exp); end
        else $display("pass kernel_no_ack %h", got);
        exp = exp_q.pop_front(); got = 32'(link_busy); checks++;
        if (got !== exp) begin errors++; $display("FAIL kernel_no_busy: got %h, expected %h", got, exp); end
        else $display("pass kernel_no_busy %h", got);
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL kernel_r31_kept: got %h, expected %h", got, exp); end
        else $display("pass kernel_r31_kept %h", got);
        irq = 1'b0; pc = 32'h0040_0000;
    endtask

    task automatic test_reset_mid_capture;
        pc = 32'h0040_0040; irq = 1'b1; set_rd(0, 31);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h1111_2222;
        exp_q.push_back(32'h1);
        tick();
        wr_en = 1'b0; irq = 1'b0;
        exp = exp_q.pop_front(); got = 32'(link_busy); checks++;
        if (got !== exp) begin errors++; $display("FAIL midcap_pending_busy: got %h, expected %h", got, exp); end
        else $display("pass midcap_pending_busy %h", got);
        #2 reset = 1'b1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        #1;
        exp = exp_q.pop_front(); got = 32'(link_busy); checks++;
        if (got !== exp) begin errors++; $display("FAIL midcap_reset_busy: got %h, expected %h", got, exp); end
        else $display("pass midcap_reset_busy %h", got);
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL midcap_reset_r31: got %h, expected %h", got, exp); end
        else $display("pass midcap_reset_r31 %h", got);
        @(negedge clk) reset = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        tick();
        exp = exp_q.pop_front(); got = 32'(irq_ack); checks++;
        if (got !== exp) begin errors++; $display("FAIL midcap_no_ack: got %h, expected %h", got, exp); end
        else $display("pass midcap_no_ack %h", got);
        exp = exp_q.pop_front(); got = rd1; checks++;
        if (got !== exp) begin errors++; $display("FAIL midcap_no_link_write: got %h, expected %h", got, exp); end
        else $display("pass midcap_no_link_write %h", got);
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_capture();
        test_round_trip();
        test_collision();
        test_wrap_kernel();
        test_reset_mid_capture();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
